// File: rtl/ma_mem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ma_mem_arbiter_if                                       |
// | Description : Bundle of the pipeline (P), host (H) and RAM-side       |
// |               signals shared by the MA-stage memory arbiter.          |
// | Revision    : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
interface ma_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  // Pipeline requester
  logic              p_req;
  logic              p_we;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_wdata;
  logic              p_ack;
  logic [DATA_W-1:0] p_rdata;
  // Host requester
  logic              h_req;
  logic              h_we;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_wdata;
  logic              h_ack;
  logic [DATA_W-1:0] h_rdata;
  // Single-port RAM side
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  // Status
  logic              busy;
  logic              gnt_h;

  // Arbiter view
  modport slave (
    input  p_req, p_we, p_addr, p_wdata,
    input  h_req, h_we, h_addr, h_wdata,
    input  mem_rdata,
    output p_ack, p_rdata, h_ack, h_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy, gnt_h
  );

  // Requesters and RAM view
  modport master (
    output p_req, p_we, p_addr, p_wdata,
    output h_req, h_we, h_addr, h_wdata,
    output mem_rdata,
    input  p_ack, p_rdata, h_ack, h_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy, gnt_h
  );
endinterface
`default_nettype wire

// File: rtl/ma_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ma_mem_arbiter                                          |
// | Description : Shares one single-port RAM between the pipeline port    |
// |               (P) and the host port (H). Four-phase REQ/ACK per port, |
// |               one access in flight, IDLE -> ISSUE -> RESP sequence.   |
// |               Ties resolved round-robin (LAST updated on ties only).  |
// |               Define MA_ARB_HOST_PRIO_EN for strict host priority.    |
// | Revision    : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
module ma_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  ma_mem_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;

  // ARMED flags: a port becomes eligible again only after REQ returns to 0
  logic              r_armed_p;
  logic              r_armed_h;
  logic              w_elig_p;
  logic              w_elig_h;
  logic              w_grant;
  logic              w_win_h;

  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_p_ack;
  logic              r_h_ack;
  logic [DATA_W-1:0] r_p_rdata;
  logic [DATA_W-1:0] r_h_rdata;
  logic              r_busy;
  logic              r_gnt_h;

  logic              w_mem_en_nxt;
  logic              w_p_ack_nxt;
  logic              w_h_ack_nxt;
  logic              w_busy_nxt;
  logic              w_load_resp_p;
  logic              w_load_resp_h;

  assign w_elig_p = bus.p_req & r_armed_p;
  assign w_elig_h = bus.h_req & r_armed_h;
  assign w_grant  = (r_state == S_IDLE) & (w_elig_p | w_elig_h);

`ifdef MA_ARB_HOST_PRIO_EN
  // Strict priority: host wins whenever it is eligible
  always_comb w_win_h = w_elig_h;
`else
  logic r_last_h;
  logic w_tie;
  assign w_tie = w_elig_p & w_elig_h;
  // Round-robin: on a tie the port that did not win the previous tie is chosen
  always_comb w_win_h = w_tie ? ~r_last_h : w_elig_h;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_elig_p | w_elig_h) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the next state so that every strobe comes out of a flop
  always_comb begin
    w_mem_en_nxt = (w_state_nxt == S_ISSUE);
    w_p_ack_nxt  = (w_state_nxt == S_RESP) & ~r_gnt_h;
    w_h_ack_nxt  = (w_state_nxt == S_RESP) &  r_gnt_h;
    w_busy_nxt   = (w_state_nxt != S_IDLE);
  end

  // Registered strobes; reset drops them on the very next edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_en <= 1'b0;
      r_p_ack  <= 1'b0;
      r_h_ack  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_mem_en <= w_mem_en_nxt;
      r_p_ack  <= w_p_ack_nxt;
      r_h_ack  <= w_h_ack_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  // A load is completing in the ACK cycle of its owner
  assign w_load_resp_p = r_p_ack & ~r_mem_we;
  assign w_load_resp_h = r_h_ack & ~r_mem_we;

  // Grant capture, read-data hold registers, ARMED and LAST bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_gnt_h     <= 1'b0;
      r_p_rdata   <= '0;
      r_h_rdata   <= '0;
      r_armed_p   <= 1'b1;
      r_armed_h   <= 1'b1;
`ifndef MA_ARB_HOST_PRIO_EN
      r_last_h    <= 1'b1;
`endif
    end else begin
      if (w_grant) begin
        r_gnt_h     <= w_win_h;
        r_mem_we    <= w_win_h ? bus.h_we    : bus.p_we;
        r_mem_addr  <= w_win_h ? bus.h_addr  : bus.p_addr;
        r_mem_wdata <= w_win_h ? bus.h_wdata : bus.p_wdata;
`ifndef MA_ARB_HOST_PRIO_EN
        if (w_tie) r_last_h <= w_win_h;
`endif
      end
      if (w_load_resp_p) r_p_rdata <= bus.mem_rdata;
      if (w_load_resp_h) r_h_rdata <= bus.mem_rdata;
      // REQ seen low re-arms (even in the ACK cycle itself); ACK disarms
      r_armed_p <= ~bus.p_req | (r_armed_p & ~r_p_ack);
      r_armed_h <= ~bus.h_req | (r_armed_h & ~r_h_ack);
    end
  end

  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.p_ack     = r_p_ack;
  assign bus.h_ack     = r_h_ack;
  assign bus.busy      = r_busy;
  assign bus.gnt_h     = r_gnt_h;
  // The RAM presents load data only in the ACK cycle, so that cycle forwards
  // it straight from the RAM output; afterwards the captured copy is held.
  assign bus.p_rdata   = w_load_resp_p ? bus.mem_rdata : r_p_rdata;
  assign bus.h_rdata   = w_load_resp_h ? bus.mem_rdata : r_h_rdata;

endmodule
`default_nettype wire

// File: tb/tb_ma_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_ma_mem_arbiter                                       |
// | Description : Directed self-checking bench for ma_mem_arbiter with a  |
// |               synchronous single-port RAM model.                      |
// | Revision    : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
module tb_ma_mem_arbiter;

`ifdef MA_ARB_HOST_PRIO_EN
  localparam bit c_host_prio = 1'b1;
`else
  localparam bit c_host_prio = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  ma_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  ma_mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: read data appears the cycle after MEM_EN
  logic [15:0] ram [0:255];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr[7:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Both ports store in the same cycle; the first winner is exp_h
  task automatic tie(input bit exp_h, input logic [15:0] pa, input logic [15:0] pd,
                     input logic [15:0] ha, input logic [15:0] hd);
    bus.p_req = 1'b1; bus.p_we = 1'b1; bus.p_addr = pa; bus.p_wdata = pd;
    bus.h_req = 1'b1; bus.h_we = 1'b1; bus.h_addr = ha; bus.h_wdata = hd;
    tick();
    check("tie_en1", bus.mem_en, 1);
    check("tie_gnt1", bus.gnt_h, exp_h);
    check("tie_addr1", bus.mem_addr, exp_h ? ha : pa);
    tick();
    check("tie_ack1", exp_h ? bus.h_ack : bus.p_ack, 1);
    check("tie_noack2", exp_h ? bus.p_ack : bus.h_ack, 0);
    if (exp_h) bus.h_req = 1'b0; else bus.p_req = 1'b0;
    tick();
    check("tie_idle", bus.busy, 0);
    tick();
    check("tie_en2", bus.mem_en, 1);
    check("tie_gnt2", bus.gnt_h, !exp_h);
    check("tie_wdata2", bus.mem_wdata, exp_h ? pd : hd);
    tick();
    check("tie_ack2", exp_h ? bus.p_ack : bus.h_ack, 1);
    bus.p_req = 1'b0;
    bus.h_req = 1'b0;
    tick();
  endtask

  initial begin
    int  en_cnt;
    int  lat;
    bit  got;
    bus.p_req = 0; bus.p_we = 0; bus.p_addr = 0; bus.p_wdata = 0;
    bus.h_req = 0; bus.h_we = 0; bus.h_addr = 0; bus.h_wdata = 0;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_mem_en", bus.mem_en, 0);
    check("rst_acks", {bus.p_ack, bus.h_ack}, 0);
    check("rst_busy_gnt", {bus.busy, bus.gnt_h}, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_p_rdata", bus.p_rdata, 0);
    rst = 1'b0;

    // 1: P store 3 <- 10
    bus.p_req = 1; bus.p_we = 1; bus.p_addr = 16'd3; bus.p_wdata = 16'd10;
    tick();
    check("t1_mem_en", bus.mem_en, 1);
    check("t1_mem_we", bus.mem_we, 1);
    check("t1_mem_addr", bus.mem_addr, 3);
    check("t1_mem_wdata", bus.mem_wdata, 10);
    check("t1_busy", bus.busy, 1);
    check("t1_early_ack", bus.p_ack, 0);
    bus.p_addr = 16'd9; bus.p_wdata = 16'd99;
    tick();
    check("t1_p_ack", bus.p_ack, 1);
    check("t1_en_drop", bus.mem_en, 0);
    check("t1_p_rdata", bus.p_rdata, 0);
    check("t1_addr_held", bus.mem_addr, 3);
    bus.p_req = 0;
    tick();
    check("t1_ack_pulse", bus.p_ack, 0);

    // 2: P load 3, then hold REQ high
    bus.p_req = 1; bus.p_we = 0; bus.p_addr = 16'd3;
    tick();
    check("t2_mem_en", bus.mem_en, 1);
    check("t2_mem_we", bus.mem_we, 0);
    tick();
    check("t2_p_ack", bus.p_ack, 1);
    check("t2_p_rdata", bus.p_rdata, 10);
    en_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.mem_en) en_cnt++;
    end
    check("t2_no_reissue", en_cnt, 0);
    check("t2_rdata_held", bus.p_rdata, 10);
    bus.p_req = 0;
    tick();

    // 3: ties after reset, P store 2<-12 and H store 1<-15
    do_reset();
    tie(c_host_prio ? 1'b1 : 1'b0, 16'd2, 16'd12, 16'd1, 16'd15);
    tie(1'b1, 16'd5, 16'd20, 16'd6, 16'd21);

    // 4: H load 2 while P keeps cycling four-phase stores
    bus.h_req = 1; bus.h_we = 0; bus.h_addr = 16'd2;
    bus.p_req = 1; bus.p_we = 1; bus.p_addr = 16'd7; bus.p_wdata = 16'h0070;
    got = 0;
    lat = 0;
    for (int i = 1; i <= 8 && !got; i++) begin
      tick();
      if (bus.h_ack) begin
        got = 1;
        lat = i;
        check("t4_h_rdata", bus.h_rdata, 12);
        check("t4_gnt_h", bus.gnt_h, 1);
        bus.h_req = 0;
      end
      if (bus.p_ack) bus.p_req = 0;
      else if (!bus.p_req) begin
        bus.p_req = 1;
        bus.p_wdata = bus.p_wdata + 16'd1;
      end
    end
    check("t4_h_within_6", got && lat <= 6, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.p_ack) bus.p_req = 0;
      if (!bus.p_req && !bus.busy && !bus.p_ack) break;
    end
    check("t4_drained", bus.busy, 0);
    tick();

    // 5: reset during ISSUE aborts the access
    bus.p_req = 1; bus.p_we = 0; bus.p_addr = 16'd3;
    tick();
    check("t5_issue", bus.mem_en, 1);
    rst = 1'b1;
    tick();
    check("t5_en_drop", bus.mem_en, 0);
    check("t5_no_ack", bus.p_ack, 0);
    check("t5_busy", bus.busy, 0);
    rst = 1'b0;
    bus.p_req = 0;
    tick();
    check("t5_still_no_ack", bus.p_ack, 0);
    bus.p_req = 1;
    tick();
    check("t5_re_en", bus.mem_en, 1);
    tick();
    check("t5_re_ack", bus.p_ack, 1);
    check("t5_re_rdata", bus.p_rdata, 10);
    bus.p_req = 0;
    tick();

    // 6: three consecutive ties after reset
    do_reset();
    tie(c_host_prio ? 1'b1 : 1'b0, 16'd10, 16'd100, 16'd11, 16'd110);
    tie(1'b1,                      16'd12, 16'd120, 16'd13, 16'd130);
    tie(c_host_prio ? 1'b1 : 1'b0, 16'd14, 16'd140, 16'd15, 16'd150);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
